// File: rtl/bcd_timer_pkg.sv
// Shared types, limits and load-range check for the BCD HH:MM:SS timer.
package bcd_timer_pkg;

  typedef struct packed {
    logic [3:0] hr_h;
    logic [3:0] hr_l;
    logic [3:0] min_h;
    logic [3:0] min_l;
    logic [3:0] sec_h;
    logic [3:0] sec_l;
  } bcd_time_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_EXPIRED
  } state_t;

  localparam logic [3:0] SEC_MAX_H = 4'd5;
  localparam logic [7:0] HR12_MAX  = 8'h11;
  localparam logic [7:0] HR24_MAX  = 8'h23;

  // With every digit <= 9 the packed BCD hour byte orders like its numeric value.
  function automatic logic bcd_time_valid(input bcd_time_t t, input logic hour24);
    logic ok;
    ok = (t.hr_h <= 4'd9) && (t.hr_l <= 4'd9) && (t.min_h <= 4'd9) &&
         (t.min_l <= 4'd9) && (t.sec_h <= 4'd9) && (t.sec_l <= 4'd9);
    ok = ok && (t.sec_h <= SEC_MAX_H) && (t.min_h <= SEC_MAX_H);
    ok = ok && ({t.hr_h, t.hr_l} <= (hour24 ? HR24_MAX : HR12_MAX));
    return ok;
  endfunction

endpackage

// File: rtl/bcd_timer_if.sv
// Control and status bundle between the button logic, the timer core and the display.
interface bcd_timer_if;
  import bcd_timer_pkg::*;

  logic      start;
  logic      stop;
  logic      clear;
  logic      load;
  bcd_time_t load_val;
  logic      dir;
  logic      lap;
  bcd_time_t time_bcd;
  logic      running;
  logic      tick_o;
  logic      wrap;
  logic      load_err;
  bcd_time_t lap_bcd;
  logic      lap_valid;

  modport master (
    output start, stop, clear, load, load_val, dir, lap,
    input  time_bcd, running, tick_o, wrap, load_err, lap_bcd, lap_valid
  );

  modport slave (
    input  start, stop, clear, load, load_val, dir, lap,
    output time_bcd, running, tick_o, wrap, load_err, lap_bcd, lap_valid
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit counting 0..MAX; priority clr > ld > inc > dec, wrapping in both directions.
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] digit,
  output logic       at_max,
  output logic       at_zero
);

  assign at_max  = (digit == MAX);
  assign at_zero = (digit == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         digit <= 4'd0;
    else if (clr)    digit <= 4'd0;
    else if (ld)     digit <= ld_val;
    else if (inc)    digit <= at_max ? 4'd0 : digit + 4'd1;
    else if (dec)    digit <= at_zero ? MAX : digit - 4'd1;
  end

endmodule

// File: rtl/bcd_timer_core.sv
// Prescaled BCD HH:MM:SS up/down timer with run/pause FSM and preset load.
// Optional lap capture is built when the LAP_EN macro is defined.
module bcd_timer_core
  import bcd_timer_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter bit HOUR_24  = 1'b0
) (
  input logic        clk,
  input logic        rst,
  bcd_timer_if.slave bus
);

  localparam int             PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0]     HR_MAX  = HOUR_24 ? HR24_MAX : HR12_MAX;

  state_t        state, state_next;
  logic [PW-1:0] presc;
  bcd_time_t     cur;
  logic          running_q, wrap_q, load_err_q;
  logic          ld_take, load_bad;
  logic          tick, cnt, count_up, count_dn, expire, is_zero, is_one;
  logic          sl_max, sh_max, ml_max, mh_max, hl_max, hh_max;
  logic          sl_zero, sh_zero, ml_zero, mh_zero, hl_zero, hh_zero;
  logic          inc_sh, inc_ml, inc_mh, c_hr, hr_wrap, inc_hl, inc_hh;
  logic          dec_sh, dec_ml, dec_mh, dec_hl, dec_hh;

  assign tick     = (state == ST_RUN) && (presc == PRE_MAX);
  assign cnt      = tick && !bus.clear;
  assign is_zero  = sl_zero && sh_zero && ml_zero && mh_zero && hl_zero && hh_zero;
  assign is_one   = (cur == bcd_time_t'(24'h000001));
  // A down tick at 00:00:01 (or already at zero) ends the countdown.
  assign expire   = cnt && bus.dir && (is_one || is_zero);
  assign count_up = cnt && !bus.dir;
  assign count_dn = cnt && bus.dir && !is_zero;

  assign inc_sh  = count_up && sl_max;
  assign inc_ml  = inc_sh && sh_max;
  assign inc_mh  = inc_ml && ml_max;
  assign c_hr    = inc_mh && mh_max;
  assign hr_wrap = c_hr && hh_max && (cur.hr_l == HR_MAX[3:0]);
  assign inc_hl  = c_hr && !hr_wrap;
  assign inc_hh  = inc_hl && hl_max;

  assign dec_sh = count_dn && sl_zero;
  assign dec_ml = dec_sh && sh_zero;
  assign dec_mh = dec_ml && ml_zero;
  assign dec_hl = dec_mh && mh_zero;
  assign dec_hh = dec_hl && hl_zero;

  bcd_digit #(.MAX(4'd9)) u_sl (.clk(clk), .rst(rst), .inc(count_up), .dec(count_dn),
    .clr(bus.clear), .ld(ld_take), .ld_val(bus.load_val.sec_l),
    .digit(cur.sec_l), .at_max(sl_max), .at_zero(sl_zero));
  bcd_digit #(.MAX(SEC_MAX_H)) u_sh (.clk(clk), .rst(rst), .inc(inc_sh), .dec(dec_sh),
    .clr(bus.clear), .ld(ld_take), .ld_val(bus.load_val.sec_h),
    .digit(cur.sec_h), .at_max(sh_max), .at_zero(sh_zero));
  bcd_digit #(.MAX(4'd9)) u_ml (.clk(clk), .rst(rst), .inc(inc_ml), .dec(dec_ml),
    .clr(bus.clear), .ld(ld_take), .ld_val(bus.load_val.min_l),
    .digit(cur.min_l), .at_max(ml_max), .at_zero(ml_zero));
  bcd_digit #(.MAX(SEC_MAX_H)) u_mh (.clk(clk), .rst(rst), .inc(inc_mh), .dec(dec_mh),
    .clr(bus.clear), .ld(ld_take), .ld_val(bus.load_val.min_h),
    .digit(cur.min_h), .at_max(mh_max), .at_zero(mh_zero));
  bcd_digit #(.MAX(4'd9)) u_hl (.clk(clk), .rst(rst), .inc(inc_hl), .dec(dec_hl),
    .clr(bus.clear || hr_wrap), .ld(ld_take), .ld_val(bus.load_val.hr_l),
    .digit(cur.hr_l), .at_max(hl_max), .at_zero(hl_zero));
  bcd_digit #(.MAX(HR_MAX[7:4])) u_hh (.clk(clk), .rst(rst), .inc(inc_hh), .dec(dec_hh),
    .clr(bus.clear || hr_wrap), .ld(ld_take), .ld_val(bus.load_val.hr_h),
    .digit(cur.hr_h), .at_max(hh_max), .at_zero(hh_zero));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Same-cycle priority: clear, then load, then start, then stop; expiry follows the count.
  always_comb begin
    state_next = state;
    ld_take    = 1'b0;
    load_bad   = 1'b0;
    if (bus.clear) begin
      state_next = ST_IDLE;
    end else if (bus.load && (state != ST_RUN)) begin
      if (bcd_time_valid(bus.load_val, HOUR_24)) begin
        ld_take = 1'b1;
        if (state == ST_EXPIRED) state_next = ST_IDLE;
      end else begin
        load_bad = 1'b1;
      end
    end else if (bus.start) begin
      if (((state == ST_IDLE) || (state == ST_PAUSE)) && !(bus.dir && is_zero))
        state_next = ST_RUN;
    end else if (bus.stop) begin
      if (state == ST_RUN) state_next = ST_PAUSE;
    end
    if (expire) state_next = ST_EXPIRED;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      if (bus.clear || ld_take)  presc <= '0;
      else if (state == ST_RUN)  presc <= tick ? '0 : presc + PW'(1);
      running_q  <= (state_next == ST_RUN);
      wrap_q     <= hr_wrap || expire;
      load_err_q <= load_bad;
    end
  end

  assign bus.time_bcd = cur;
  assign bus.running  = running_q;
  assign bus.tick_o   = tick;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;

`ifdef LAP_EN
  bcd_time_t lap_q;
  logic      lap_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_q <= '0;
      lap_v <= 1'b0;
    end else if (bus.clear) begin
      lap_q <= '0;
      lap_v <= 1'b0;
    end else if (bus.lap && ((state == ST_RUN) || (state == ST_PAUSE))) begin
      lap_q <= cur;
      lap_v <= 1'b1;
    end
  end

  assign bus.lap_bcd   = lap_q;
  assign bus.lap_valid = lap_v;
`else
  logic unused_lap;
  assign unused_lap    = bus.lap;
  assign bus.lap_bcd   = '0;
  assign bus.lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_timer_core.sv
// Scoreboard bench for bcd_timer_core: 12h instance (TICK_DIV=4) plus 24h instance (TICK_DIV=1).
module tb_bcd_timer_core;
  import bcd_timer_pkg::*;

  typedef struct packed {
    logic [1:0]  flags;   // {wrap, load_err}
    logic [23:0] t;
  } evt_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_timer_if ia ();
  bcd_timer_if ib ();

  bcd_timer_core #(.TICK_DIV(4), .HOUR_24(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  bcd_timer_core #(.TICK_DIV(1), .HOUR_24(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  logic [23:0] time_q [$];
  evt_t        evt_q  [$];
  int          checks   = 0;
  int          failures = 0;
  int          tick_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic push_range(input int from, input int to);
    if (from <= to) for (int s = from; s <= to; s++) time_q.push_back(to_bcd(s));
    else            for (int s = from; s >= to; s--) time_q.push_back(to_bcd(s));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every change of time_bcd and every wrap/load_err pulse consumes one expectation.
  initial begin
    logic [23:0] prev;
    logic [23:0] e;
    evt_t        ev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (ia.time_bcd != prev) begin
        if (time_q.size() == 0) check("time_unexpected", {8'h0, ia.time_bcd}, {8'h0, prev});
        else begin
          e = time_q.pop_front();
          check("time_seq", {8'h0, ia.time_bcd}, {8'h0, e});
        end
        prev = ia.time_bcd;
      end
      if (ia.wrap || ia.load_err) begin
        if (evt_q.size() == 0) check("evt_unexpected", {30'h0, ia.wrap, ia.load_err}, 32'h0);
        else begin
          ev = evt_q.pop_front();
          check("evt_flags", {30'h0, ia.wrap, ia.load_err}, {30'h0, ev.flags});
          check("evt_time", {8'h0, ia.time_bcd}, {8'h0, ev.t});
        end
      end
      if (ia.tick_o) tick_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] bad_vals [4];
    bad_vals[0] = 24'h006000;
    bad_vals[1] = 24'h120000;
    bad_vals[2] = 24'h00000A;
    bad_vals[3] = 24'h000060;

    {ia.start, ia.stop, ia.clear, ia.load, ia.dir, ia.lap} = '0;
    {ib.start, ib.stop, ib.clear, ib.load, ib.dir, ib.lap} = '0;
    ia.load_val = '0;
    ib.load_val = '0;
    rst = 1'b1;
    cyc(3);
    check("rst_time",      {8'h0, ia.time_bcd}, 32'h0);
    check("rst_running",   ia.running, 1'b0);
    check("rst_wrap",      ia.wrap, 1'b0);
    check("rst_load_err",  ia.load_err, 1'b0);
    check("rst_tick",      ia.tick_o, 1'b0);
    check("rst_lap_valid", ia.lap_valid, 1'b0);
    check("rst_lap_bcd",   {8'h0, ia.lap_bcd}, 32'h0);
    check("rst_b_lap",     {7'h0, ib.lap_valid, ib.lap_bcd}, 32'h0);
    rst = 1'b0;
    cyc(1);

    // Count up one minute: 60 ticks at 4 cycles each.
    tick_cnt = 0;
    push_range(1, 60);
    ia.start = 1'b1; cyc(1); ia.start = 1'b0;
    check("run_after_start", ia.running, 1'b1);
    cyc(240);
    check("minute_time", {8'h0, ia.time_bcd}, 32'h000100);
    check("minute_ticks", tick_cnt, 60);

    // Pause with two cycles of the current second elapsed; resume keeps the fraction.
    cyc(2);
    ia.stop = 1'b1; cyc(1); ia.stop = 1'b0;
    check("pause_running", ia.running, 1'b0);
    cyc(10);
    check("pause_no_tick", ia.tick_o, 1'b0);
    check("pause_time", {8'h0, ia.time_bcd}, 32'h000100);
    time_q.push_back(24'h000101);
    ia.start = 1'b1; cyc(1); ia.start = 1'b0;
    check("resume_tick_now", ia.tick_o, 1'b1);
    cyc(1);
    check("resume_time", {8'h0, ia.time_bcd}, 32'h000101);

    time_q.push_back(24'h000000);
    ia.clear = 1'b1; ia.start = 1'b1; cyc(1); ia.clear = 1'b0; ia.start = 1'b0;
    check("clear_start_running", ia.running, 1'b0);
    check("clear_start_time", {8'h0, ia.time_bcd}, 32'h0);

    // 12-hour rollover from 11:59:58.
    time_q.push_back(24'h115958);
    ia.load_val = 24'h115958; ia.load = 1'b1; cyc(1); ia.load = 1'b0;
    time_q.push_back(24'h115959);
    time_q.push_back(24'h000000);
    evt_q.push_back({2'b10, 24'h000000});
    ia.start = 1'b1; cyc(1); ia.start = 1'b0;
    cyc(8);
    check("wrap12_time", {8'h0, ia.time_bcd}, 32'h0);
    check("wrap12_pulse", ia.wrap, 1'b1);
    ia.stop = 1'b1; cyc(1); ia.stop = 1'b0;
    check("wrap12_stopped", ia.running, 1'b0);

    // Countdown from 00:01:01 to expiry.
    ia.dir = 1'b1;
    time_q.push_back(to_bcd(61));
    ia.load_val = 24'h000101; ia.load = 1'b1; cyc(1); ia.load = 1'b0;
    push_range(60, 0);
    evt_q.push_back({2'b10, 24'h000000});
    ia.start = 1'b1; cyc(1); ia.start = 1'b0;
    cyc(244);
    check("expired_running", ia.running, 1'b0);
    check("expired_time", {8'h0, ia.time_bcd}, 32'h0);
    check("expired_wrap", ia.wrap, 1'b1);
    cyc(1);
    ia.start = 1'b1; cyc(1); ia.start = 1'b0;
    check("expired_ignores_start", ia.running, 1'b0);
    check("expired_tick", ia.tick_o, 1'b0);

    ia.load_val = 24'h000000; ia.load = 1'b1; cyc(1); ia.load = 1'b0;
    ia.start = 1'b1; cyc(1); ia.start = 1'b0;
    check("down_zero_start_ignored", ia.running, 1'b0);
    time_q.push_back(24'h000003);
    ia.load_val = 24'h000003; ia.load = 1'b1; cyc(1); ia.load = 1'b0;
    ia.start = 1'b1; cyc(1); ia.start = 1'b0;
    check("idle_after_expired_load", ia.running, 1'b1);
    ia.stop = 1'b1; cyc(1); ia.stop = 1'b0;
    check("stop_again", ia.running, 1'b0);

    // Rejected loads while paused.
    for (int i = 0; i < 4; i++) begin
      evt_q.push_back({2'b01, 24'h000003});
      ia.load_val = bad_vals[i]; ia.load = 1'b1; cyc(1); ia.load = 1'b0;
      check("load_err_pulse", ia.load_err, 1'b1);
      cyc(1);
      check("load_err_once", ia.load_err, 1'b0);
    end
    check("bad_load_time", {8'h0, ia.time_bcd}, 32'h000003);

    // Load during RUN is ignored; then a lap on a tick edge.
    time_q.push_back(24'h000000);
    ia.clear = 1'b1; cyc(1); ia.clear = 1'b0;
    ia.dir = 1'b0;
    time_q.push_back(to_bcd(1));
    ia.start = 1'b1; cyc(1); ia.start = 1'b0;
    ia.load_val = 24'h050000; ia.load = 1'b1; cyc(1); ia.load = 1'b0;
    cyc(3);
    check("run_load_ignored", {8'h0, ia.time_bcd}, 32'h000001);
    check("run_load_running", ia.running, 1'b1);
    push_range(2, 8);
    cyc(27);
    ia.lap = 1'b1; cyc(1); ia.lap = 1'b0;
    check("lap_edge_time", {8'h0, ia.time_bcd}, 32'h000008);
`ifdef LAP_EN
    check("lap_bcd", {8'h0, ia.lap_bcd}, 32'h000007);
    check("lap_valid", ia.lap_valid, 1'b1);
`else
    check("lap_bcd_off", {8'h0, ia.lap_bcd}, 32'h0);
    check("lap_valid_off", ia.lap_valid, 1'b0);
`endif
    time_q.push_back(24'h000000);
    ia.clear = 1'b1; cyc(1); ia.clear = 1'b0;
    check("clear_lap_valid", ia.lap_valid, 1'b0);
    check("clear_running", ia.running, 1'b0);

    // 24-hour instance, one tick per RUN cycle.
    ib.load_val = 24'h240000; ib.load = 1'b1; cyc(1); ib.load = 1'b0;
    check("b_load_err", ib.load_err, 1'b1);
    check("b_bad_time", {8'h0, ib.time_bcd}, 32'h0);
    cyc(1);
    check("b_load_err_once", ib.load_err, 1'b0);
    ib.load_val = 24'h195959; ib.load = 1'b1; cyc(1); ib.load = 1'b0;
    ib.start = 1'b1; cyc(1); ib.start = 1'b0;
    cyc(1);
    check("b_hour_carry", {8'h0, ib.time_bcd}, 32'h200000);
    ib.clear = 1'b1; cyc(1); ib.clear = 1'b0;
    ib.load_val = 24'h235959; ib.load = 1'b1; cyc(1); ib.load = 1'b0;
    check("b_load_ok", {8'h0, ib.time_bcd}, 32'h235959);
    ib.start = 1'b1; cyc(1); ib.start = 1'b0;
    check("b_running", ib.running, 1'b1);
    check("b_tick_every_cycle", ib.tick_o, 1'b1);
    cyc(1);
    check("b_wrap24_time", {8'h0, ib.time_bcd}, 32'h0);
    check("b_wrap24_pulse", ib.wrap, 1'b1);
    ib.clear = 1'b1; cyc(1); ib.clear = 1'b0;
    check("b_clear_running", ib.running, 1'b0);
    check("b_clear_wrap", ib.wrap, 1'b0);

    // Asynchronous reset in the middle of a running count.
    time_q.push_back(24'h000005);
    ia.load_val = 24'h000005; ia.load = 1'b1; cyc(1); ia.load = 1'b0;
    ia.start = 1'b1; cyc(1); ia.start = 1'b0;
    time_q.push_back(24'h000000);
    #2 rst = 1'b1;
    #1;
    check("async_rst_time", {8'h0, ia.time_bcd}, 32'h0);
    check("async_rst_running", ia.running, 1'b0);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    check("time_q_drained", time_q.size(), 0);
    check("evt_q_drained", evt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
